// File: rtl/ps2_direction_decoder.sv
// PS/2 scancode parser that tracks held arrow keys (player 0) and WDSA (player 1)
// and resolves each player's held set to a single registered direction.
module ps2_direction_decoder #(
    parameter int unsigned PREFIX_TIMEOUT = 1000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_key_pressed,
    input  logic [7:0] ps2_out,
    output logic       upSig,
    output logic       rightSig,
    output logic       downSig,
    output logic       leftSig,
    output logic       upSig2,
    output logic       rightSig2,
    output logic       downSig2,
    output logic       leftSig2,
    output logic [2:0] dir0_code,
    output logic [2:0] dir1_code
);

    typedef enum logic [1:0] {StIdle, StGotE0, StGotF0, StGotE0F0} state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  held0_q, held0_d, held1_q, held1_d;
    logic [2:0]  last0_q, last0_d, last1_q, last1_d;
    logic [2:0]  dir0_q, dir1_q;
    logic [2:0]  res0, res1, code0, code1;
    logic        make0, brk0, make1, brk1;

    // Direction code: 0 none, 1 up, 2 right, 3 down, 4 left; held bit = code - 1.
    function automatic logic [3:0] dir_bit(input logic [2:0] code);
        case (code)
            3'd1:    return 4'b0001;
            3'd2:    return 4'b0010;
            3'd3:    return 4'b0100;
            3'd4:    return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [2:0] resolve(input logic [3:0] held, input logic [2:0] last);
        if ((held & dir_bit(last)) != 4'b0000) return last;
        else if (held[0]) return 3'd1;
        else if (held[1]) return 3'd2;
        else if (held[2]) return 3'd3;
        else if (held[3]) return 3'd4;
        else return 3'd0;
    endfunction

    always_comb begin
        case (ps2_out)
            8'h75:   code0 = 3'd1;
            8'h74:   code0 = 3'd2;
            8'h72:   code0 = 3'd3;
            8'h6B:   code0 = 3'd4;
            default: code0 = 3'd0;
        endcase
        case (ps2_out)
            8'h1D:   code1 = 3'd1;
            8'h23:   code1 = 3'd2;
            8'h1B:   code1 = 3'd3;
            8'h1C:   code1 = 3'd4;
            default: code1 = 3'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        make0   = 1'b0;
        brk0    = 1'b0;
        make1   = 1'b0;
        brk1    = 1'b0;
        if (ps2_key_pressed) begin
            cnt_d = 32'd0;
            unique case (state_q)
                StIdle: begin
                    if (ps2_out == 8'hE0) state_d = StGotE0;
                    else if (ps2_out == 8'hF0) state_d = StGotF0;
                    else make1 = 1'b1;
                end
                StGotE0: begin
                    if (ps2_out == 8'hF0) state_d = StGotE0F0;
                    else if (ps2_out != 8'hE0) begin
                        make0   = 1'b1;
                        state_d = StIdle;
                    end
                end
                StGotF0: begin
                    if (ps2_out == 8'hE0) state_d = StGotE0F0;
                    else if (ps2_out != 8'hF0) begin
                        brk1    = 1'b1;
                        state_d = StIdle;
                    end
                end
                StGotE0F0: begin
                    if (ps2_out != 8'hE0 && ps2_out != 8'hF0) begin
                        brk0    = 1'b1;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end else if (state_q != StIdle) begin
            // Abandon a stalled prefix after PREFIX_TIMEOUT idle cycles.
            if (cnt_q >= 32'(PREFIX_TIMEOUT - 1)) begin
                state_d = StIdle;
                cnt_d   = 32'd0;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    always_comb begin
        res0    = resolve(held0_q, last0_q);
        res1    = resolve(held1_q, last1_q);
        held0_d = held0_q;
        held1_d = held1_q;
        last0_d = res0;
        last1_d = res1;
        if (make0 && code0 != 3'd0) begin
            held0_d = held0_q | dir_bit(code0);
            last0_d = code0;
        end
        if (brk0) held0_d = held0_q & ~dir_bit(code0);
        if (make1 && code1 != 3'd0) begin
            held1_d = held1_q | dir_bit(code1);
            last1_d = code1;
        end
        if (brk1) held1_d = held1_q & ~dir_bit(code1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 32'd0;
            held0_q <= 4'b0000;
            held1_q <= 4'b0000;
            last0_q <= 3'd0;
            last1_q <= 3'd0;
            dir0_q  <= 3'd0;
            dir1_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            held0_q <= held0_d;
            held1_q <= held1_d;
            last0_q <= last0_d;
            last1_q <= last1_d;
            dir0_q  <= res0;
            dir1_q  <= res1;
        end
    end

    assign dir0_code = dir0_q;
    assign dir1_code = dir1_q;
    assign upSig     = (dir0_q == 3'd1);
    assign rightSig  = (dir0_q == 3'd2);
    assign downSig   = (dir0_q == 3'd3);
    assign leftSig   = (dir0_q == 3'd4);
    assign upSig2    = (dir1_q == 3'd1);
    assign rightSig2 = (dir1_q == 3'd2);
    assign downSig2  = (dir1_q == 3'd3);
    assign leftSig2  = (dir1_q == 3'd4);

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Directed bench for ps2_direction_decoder: table of byte strobes with expected
// per-player direction codes, plus timeout and reset sequences.
module tb_ps2_direction_decoder;

    localparam int unsigned Timeout = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_key_pressed = 1'b0;
    logic [7:0] ps2_out = 8'h00;
    logic       upSig, rightSig, downSig, leftSig;
    logic       upSig2, rightSig2, downSig2, leftSig2;
    logic [2:0] dir0_code, dir1_code;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] b;
        logic [2:0] e0;
        logic [2:0] e1;
    } vec_t;

    vec_t vecs[$];

    ps2_direction_decoder #(.PREFIX_TIMEOUT(Timeout)) dut (
        .clock           (clock),
        .reset           (reset),
        .ps2_key_pressed (ps2_key_pressed),
        .ps2_out         (ps2_out),
        .upSig           (upSig),
        .rightSig        (rightSig),
        .downSig         (downSig),
        .leftSig         (leftSig),
        .upSig2          (upSig2),
        .rightSig2       (rightSig2),
        .downSig2        (downSig2),
        .leftSig2        (leftSig2),
        .dir0_code       (dir0_code),
        .dir1_code       (dir1_code)
    );

    always #5 clock = ~clock;

    // {up, right, down, left} expected for a direction code.
    function automatic logic [3:0] sigs_of(input logic [2:0] code);
        case (code)
            3'd1:    return 4'b1000;
            3'd2:    return 4'b0100;
            3'd3:    return 4'b0010;
            3'd4:    return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check(input string tag, input logic [2:0] e0, input logic [2:0] e1);
        cmp({tag, " dir0_code"}, {1'b0, dir0_code}, {1'b0, e0});
        cmp({tag, " p0 sigs"}, {upSig, rightSig, downSig, leftSig}, sigs_of(e0));
        cmp({tag, " dir1_code"}, {1'b0, dir1_code}, {1'b0, e1});
        cmp({tag, " p1 sigs"}, {upSig2, rightSig2, downSig2, leftSig2}, sigs_of(e1));
    endtask

    // Drive one byte strobe for a single posedge; returns on the following negedge.
    task automatic send(input logic [7:0] b);
        ps2_key_pressed = 1'b1;
        ps2_out         = b;
        @(negedge clock);
        ps2_key_pressed = 1'b0;
        ps2_out         = 8'h00;
    endtask

    task automatic add(input logic [7:0] b, input logic [2:0] e0, input logic [2:0] e1);
        vec_t v;
        v.b  = b;
        v.e0 = e0;
        v.e1 = e1;
        vecs.push_back(v);
    endtask

    initial begin
        // p0 up make/break
        add(8'hE0, 0, 0); add(8'h75, 1, 0);
        add(8'hE0, 1, 0); add(8'hF0, 1, 0); add(8'h75, 0, 0);
        // p1 W then D, release D falls back to W, release W
        add(8'h1D, 0, 1); add(8'h23, 0, 2);
        add(8'hF0, 0, 2); add(8'h23, 0, 1);
        add(8'hF0, 0, 1); add(8'h1D, 0, 0);
        // p0 left then down, release in turn
        add(8'hE0, 0, 0); add(8'h6B, 4, 0);
        add(8'hE0, 4, 0); add(8'h72, 3, 0);
        add(8'hE0, 3, 0); add(8'hF0, 3, 0); add(8'h72, 4, 0);
        add(8'hE0, 4, 0); add(8'hF0, 4, 0); add(8'h6B, 0, 0);
        // keypad 75 and E0 1D ignored, parser back to idle
        add(8'h75, 0, 0); add(8'hE0, 0, 0); add(8'h1D, 0, 0);
        add(8'h1B, 0, 3); add(8'hF0, 0, 3); add(8'h1B, 0, 0);
        // break of a key not held
        add(8'hF0, 0, 0); add(8'h23, 0, 0);
        add(8'hE0, 0, 0); add(8'hF0, 0, 0); add(8'h74, 0, 0);
        // repeated E0 stays extended; F0 E0 forms an extended break
        add(8'hE0, 0, 0); add(8'hE0, 0, 0); add(8'h74, 2, 0);
        add(8'hF0, 2, 0); add(8'hE0, 2, 0); add(8'h74, 0, 0);
        // typematic reload of last_dir
        add(8'hE0, 0, 0); add(8'h75, 1, 0); add(8'hE0, 1, 0); add(8'h75, 1, 0);
        add(8'hE0, 1, 0); add(8'h74, 2, 0); add(8'hE0, 2, 0); add(8'h75, 1, 0);
        add(8'hE0, 1, 0); add(8'hF0, 1, 0); add(8'h75, 2, 0);
        // independence: p1 left while p0 right held
        add(8'h1C, 2, 4);
        add(8'hE0, 2, 4); add(8'hF0, 2, 4); add(8'h74, 0, 4);
        add(8'hF0, 0, 4); add(8'h1C, 0, 0);
        // priority fallback when last_dir is released: left, down, right held
        add(8'hE0, 0, 0); add(8'h6B, 4, 0); add(8'hE0, 4, 0); add(8'h72, 3, 0);
        add(8'hE0, 3, 0); add(8'h74, 2, 0);
        add(8'hE0, 2, 0); add(8'hF0, 2, 0); add(8'h74, 3, 0);
        add(8'hE0, 3, 0); add(8'hF0, 3, 0); add(8'h72, 4, 0);
        add(8'hE0, 4, 0); add(8'hF0, 4, 0); add(8'h6B, 0, 0);

        repeat (2) @(negedge clock);
        check("reset", 0, 0);
        reset = 1'b0;
        @(negedge clock);
        check("post-reset", 0, 0);

        foreach (vecs[i]) begin
            send(vecs[i].b);
            @(negedge clock);
            check($sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1);
        end

        // Stalled E0 times out; 74 is then a plain unmapped byte.
        send(8'hE0);
        repeat (Timeout + 4) @(negedge clock);
        send(8'h74);
        @(negedge clock);
        check("timeout e0", 0, 0);
        // Short gap keeps the prefix alive.
        send(8'hE0);
        repeat (4) @(negedge clock);
        send(8'h74);
        @(negedge clock);
        check("no timeout e0", 2, 0);
        send(8'hE0); send(8'hF0); send(8'h74);
        @(negedge clock);
        check("release right", 0, 0);
        // Stalled F0 times out; 1D becomes a make.
        send(8'hF0);
        repeat (Timeout + 4) @(negedge clock);
        send(8'h1D);
        @(negedge clock);
        check("timeout f0", 0, 1);
        send(8'hF0); send(8'h1D);
        @(negedge clock);
        check("release w", 0, 0);

        // Reset with keys held.
        send(8'hE0); send(8'h75); send(8'h1C);
        @(negedge clock);
        check("hold before reset", 1, 4);
        reset = 1'b1;
        #1;
        check("async reset", 0, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("after reset", 0, 0);
        send(8'hE0); send(8'hF0); send(8'h75);
        @(negedge clock);
        check("release after reset", 0, 0);

        // Reset mid-prefix returns the parser to idle.
        send(8'hE0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        send(8'h75);
        @(negedge clock);
        check("reset mid-prefix", 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_direction_decoder.md
Name: ps2_direction_decoder

Overview:
- Converts the raw PS/2 keyboard byte stream (ps2_key_pressed / ps2_out) into the per-player direction lines upSig/rightSig/downSig/leftSig and upSig2/rightSig2/downSig2/leftSig2.
- The memory-mapped input ports 4100/4101 consume these lines, and they must drive exactly one line high, or none, for a valid code to be returned.
- Tracks make and break codes, including the E0-extended arrow keys, and keeps a held-key set per player.
- Resolves multiple held keys to one direction.

Parameters:
- PREFIX_TIMEOUT, 1000000: clock cycles a partial prefix sequence (E0 / F0 / E0 F0) may wait for its next byte before being abandoned.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- ps2_key_pressed  input  1  byte strobe; every cycle it is high at posedge delivers one byte.
- ps2_out  input  8  scancode byte, valid when ps2_key_pressed=1.
- upSig, rightSig, downSig, leftSig  output  1 each  player 0 direction; at most one high.
- upSig2, rightSig2, downSig2, leftSig2  output  1 each  player 1 direction; at most one high.
- dir0_code  output  3  player 0 direction in MMIO encoding (0 none, 1 up, 2 right, 3 down, 4 left).
- dir1_code  output  3  player 1 direction, same encoding.

Behaviour:
- Key map, player 0 (extended only): E0 75 = up, E0 74 = right, E0 72 = down, E0 6B = left. Non-extended 75/74/72/6B (keypad) are ignored.
- Key map, player 1 (non-extended only): 1D (W) = up, 23 (D) = right, 1B (S) = down, 1C (A) = left. E0-prefixed 1D/23/1B/1C are ignored.
- Breaks: F0 xx releases a player 1 key; E0 F0 xx releases a player 0 key.
- Parser FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0. All transitions below happen on a strobe only.
  - IDLE: E0 goes to GOT_E0; F0 goes to GOT_F0; any other byte is a make code (p1 table) and stays IDLE.
  - GOT_E0: F0 goes to GOT_E0F0; E0 stays GOT_E0; any other byte is an extended make (p0 table), then IDLE.
  - GOT_F0: F0 stays GOT_F0; E0 goes to GOT_E0F0; any other byte is a break (p1 table), then IDLE.
  - GOT_E0F0: E0 or F0 stays; any other byte is an extended break (p0 table), then IDLE.
  - Unmapped final bytes change nothing and return to IDLE.
- Timeout: a 32-bit counter runs while in any non-IDLE state and clears on every strobe. When it reaches PREFIX_TIMEOUT with no strobe, the FSM returns to IDLE with no key effect.
- Held set: a 4-bit held register per player. A make sets its bit and loads last_dir with that key. A break clears its bit.
- Typematic repeat of an already-held key reloads last_dir and is otherwise harmless.
- Resolution, evaluated per player on each cycle:
  - If last_dir is held, output last_dir.
  - Otherwise, output the first held key in priority up > right > down > left, and update last_dir to it.
  - If no key is held, output none (0).
- Latency: held/last update at the posedge that samples the final byte. The direction outputs and dir*_code are registered and reflect that byte one posedge later.
- Outputs are always one-hot or all-zero per player. The sig lines and dir*_code agree in the same cycle.
- A break for a key not held is a no-op. Players are fully independent; one player's byte never alters the other's state.
- Reset, asynchronous at any time including mid-sequence: FSM=IDLE, timeout counter=0, held=0 and last_dir=none for both players, all direction outputs 0, dir0_code=dir1_code=0.

Test Plan:
- Reset, then strobe E0, 75 -> after 1 cycle upSig=1, dir0_code=1, other sigs 0. Then strobe E0, F0, 75 -> upSig=0, dir0_code=0.
- Strobe 1D, then 23 (W then D held) -> rightSig2=1, dir1_code=2. Strobe F0, 23 -> upSig2=1, dir1_code=1 (fallback to still-held W).
- Hold E0 6B and E0 72 for p0 (left then down, so down is last) -> downSig=1. Release down -> leftSig=1. Release left -> all p0 sigs 0.
- Strobe 75 without prefix, and E0 1D -> no output changes for either player; FSM back in IDLE (verify by following with 1B -> downSig2=1).
- Strobe E0, then idle PREFIX_TIMEOUT cycles (bench override 16), then strobe 74 -> treated as a non-extended unmapped byte; rightSig stays 0.
- With p0 up and p1 left held, assert reset for one cycle, then deassert -> all eight sigs 0, both codes 0. A release-only sequence (E0 F0 75) afterwards causes no change.
